// File: rtl/gb_host_bridge.sv
`default_nettype none
// ============================================================================
// Module      : gb_host_bridge
// Description : Single-outstanding command/response bridge onto a strobed
//               local bus with a fixed-latency read return.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_host_bridge #(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int RD_DELAY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din,
    output logic          busy,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] c_rd_delay = 4'(RD_DELAY);
    localparam logic       c_no_wait  = (RD_DELAY == 0);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [3:0]    r_wait;
    logic [AW-1:0] r_gb_addr;
    logic [DW-1:0] r_gb_dout;
    logic          r_rsp_write;
    logic [DW-1:0] r_rsp_rdata;
    logic [15:0]   r_wr_count;
    logic [15:0]   r_rd_count;

    logic w_accept;
    logic w_capture;
    logic w_rsp_hs;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    // Read data is due at the end of cycle T+RD_DELAY, T being the gb_re cycle.
    assign w_capture = ((r_state == S_READ) && c_no_wait) ||
                       ((r_state == S_RWAIT) && (r_wait == 4'd1));
    assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = cmd_we ? S_WRITE : S_READ;
            S_WRITE: w_state_nxt = S_RESP;
            S_READ:  w_state_nxt = c_no_wait ? S_RESP : S_RWAIT;
            S_RWAIT: if (r_wait == 4'd1) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        gb_we     = (r_state == S_WRITE);
        gb_re     = (r_state == S_READ);
        rsp_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= 4'd0;
            r_gb_addr   <= '0;
            r_gb_dout   <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_wr_count  <= 16'd0;
            r_rd_count  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_gb_addr <= cmd_addr;
                if (cmd_we) r_gb_dout <= cmd_wdata;
            end
            if (r_state == S_READ) begin
                r_wait <= c_rd_delay;
            end else if (r_state == S_RWAIT) begin
                r_wait <= r_wait - 4'd1;
            end
            if (r_state == S_WRITE) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
            end else if (w_capture) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= gb_din;
            end
            if (w_rsp_hs) begin
                if (r_rsp_write) r_wr_count <= r_wr_count + 16'd1;
                else             r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign gb_addr   = r_gb_addr;
    assign gb_dout   = r_gb_dout;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_gb_host_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_host_bridge
// Description : Directed self-checking bench for gb_host_bridge with
//               RD_DELAY=2 (dut) and RD_DELAY=0 (dut0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_host_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid0;
    logic        cmd_we;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_ready;
    logic [31:0] gb_din;

    logic        cmd_ready, rsp_valid, rsp_write, gb_we, gb_re, busy;
    logic [31:0] rsp_rdata, gb_dout;
    logic [23:0] gb_addr;
    logic [15:0] wr_count, rd_count;

    logic        cmd_ready0, rsp_valid0, rsp_write0, gb_we0, gb_re0, busy0;
    logic [31:0] rsp_rdata0, gb_dout0;
    logic [23:0] gb_addr0;
    logic [15:0] wr_count0, rd_count0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gb_host_bridge #(.AW(24), .DW(32), .RD_DELAY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .gb_addr(gb_addr), .gb_dout(gb_dout),
        .gb_we(gb_we), .gb_re(gb_re), .gb_din(gb_din), .busy(busy),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    gb_host_bridge #(.AW(24), .DW(32), .RD_DELAY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_write(rsp_write0),
        .rsp_rdata(rsp_rdata0), .gb_addr(gb_addr0), .gb_dout(gb_dout0),
        .gb_we(gb_we0), .gb_re(gb_re0), .gb_din(gb_din), .busy(busy0),
        .wr_count(wr_count0), .rd_count(rd_count0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_valid0 = 1'b0;
        cmd_we     = 1'b1;
        cmd_addr   = 24'h0000AA;
        cmd_wdata  = 32'hAAAAAAAA;
        rsp_ready  = 1'b1;
        gb_din     = 32'h0;

        // Reset, with a command offered that must not be taken
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_gb_we",     64'(gb_we),     64'h0);
        check("rst_gb_addr",   64'(gb_addr),   64'h0);
        check("rst_gb_dout",   64'(gb_dout),   64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        check("rst_wr_count",  64'(wr_count),  64'h0);
        check("rst_rd_count",  64'(rd_count),  64'h0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'h0);

        // Write 0x000010 <- 0xDEADBEEF
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000010; cmd_wdata = 32'hDEADBEEF;
        check("wr_cmd_ready", 64'(cmd_ready), 64'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_gb_we",     64'(gb_we),     64'h1);
        check("wr_gb_addr",   64'(gb_addr),   64'h000010);
        check("wr_gb_dout",   64'(gb_dout),   64'hDEADBEEF);
        check("wr_cmd_ready_busy", 64'(cmd_ready), 64'h0);
        check("wr_rsp_early", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        check("wr_gb_we_once", 64'(gb_we),     64'h0);
        check("wr_rsp_valid",  64'(rsp_valid), 64'h1);
        check("wr_rsp_write",  64'(rsp_write), 64'h1);
        check("wr_rsp_rdata",  64'(rsp_rdata), 64'h0);
        @(negedge clk);
        check("wr_rsp_done",  64'(rsp_valid), 64'h0);
        check("wr_count_1",   64'(wr_count),  64'h1);
        check("wr_idle",      64'(cmd_ready), 64'h1);

        // Read 0x000020, RD_DELAY=2, data valid only at T+2
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000020; cmd_wdata = 32'h55555555;
        @(negedge clk);
        cmd_valid = 1'b0;
        gb_din = 32'hBAD0BAD0;
        check("rd_gb_re",   64'(gb_re),   64'h1);
        check("rd_gb_addr", 64'(gb_addr), 64'h000020);
        check("rd_gb_dout_kept", 64'(gb_dout), 64'hDEADBEEF);
        @(negedge clk);
        gb_din = 32'hBAD1BAD1;
        check("rd_gb_re_once", 64'(gb_re),     64'h0);
        check("rd_wait_busy",  64'(busy),      64'h1);
        check("rd_wait_rsp",   64'(rsp_valid), 64'h0);
        @(negedge clk);
        gb_din = 32'h12345678;
        check("rd_t2_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        gb_din = 32'hFFFFFFFF;
        check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        check("rd_rsp_write", 64'(rsp_write), 64'h0);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        @(negedge clk);
        check("rd_count_1", 64'(rd_count),  64'h1);
        check("rd_done",    64'(rsp_valid), 64'h0);

        // Back-pressure: read 0x000030 with rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000030;
        gb_din = 32'hCAFEF00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
            check("bp_rsp_write", 64'(rsp_write), 64'h0);
            check("bp_cmd_ready", 64'(cmd_ready), 64'h0);
            gb_din    = $urandom;
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000040; cmd_wdata = 32'h11111111;
            @(negedge clk);
        end
        check("bp_addr_kept", 64'(gb_addr), 64'h000030);
        check("bp_dout_kept", 64'(gb_dout), 64'hDEADBEEF);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rd_count", 64'(rd_count),  64'h2);
        check("bp_wr_count", 64'(wr_count),  64'h1);
        check("bp_released", 64'(rsp_valid), 64'h0);

        // RD_DELAY=0: data sampled in the gb_re cycle
        cmd_valid0 = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000050;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        gb_din = 32'h0F0F0F0F;
        check("rd0_gb_re", 64'(gb_re0), 64'h1);
        check("rd0_no_rsp_yet", 64'(rsp_valid0), 64'h0);
        @(negedge clk);
        gb_din = 32'hF0F0F0F0;
        check("rd0_rsp_valid", 64'(rsp_valid0), 64'h1);
        check("rd0_rsp_rdata", 64'(rsp_rdata0), 64'h0F0F0F0F);
        check("rd0_gb_re_once", 64'(gb_re0), 64'h0);
        @(negedge clk);
        check("rd0_rd_count", 64'(rd_count0), 64'h1);
        check("rd0_idle",     64'(busy0),     64'h0);

        // Reset pulse while in RWAIT
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000060;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",      64'(busy),      64'h0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mid_wr_count",  64'(wr_count),  64'h0);
        check("rst_mid_rd_count",  64'(rd_count),  64'h0);
        check("rst_mid_gb_addr",   64'(gb_addr),   64'h0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_no_rsp",  64'(rsp_valid), 64'h0);
            check("rst_mid_idle",    64'(busy),      64'h0);
        end
        check("rst_mid_rd_count_after", 64'(rd_count), 64'h0);

        // 65536 back-to-back writes wrap wr_count
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000070; cmd_wdata = 32'h0;
        repeat (3 * 65535) @(posedge clk);
        @(negedge clk);
        check("wrap_ffff", 64'(wr_count), 64'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wrap_zero",     64'(wr_count), 64'h0);
        check("wrap_rd_count", 64'(rd_count), 64'h0);
        check("wrap_idle",     64'(busy),     64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
